// File: rtl/mdr_mem_if.sv
// mdr_mem_if: memory data register with a simple request/acknowledge memory port.
// Reads and writes wait for mem_ack, bounded by TIMEOUT_CYC cycles.
// Optional build macro MDR_SUBWORD_EN enables byte/half reads with sign or zero
// extension; without it every read loads the full MDataIn word.
module mdr_mem_if #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MDR_enable,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [DATA_W-1:0] MDataIn,
  input  logic              mem_ack,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] Q,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  // Last wait-state edge that may still be absorbed before giving up.
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYC - 1);

  state_t            state_reg, state_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic [DATA_W-1:0] q_reg, q_next;
  logic              done_next, timeout_next;
  logic              mem_rd_reg, mem_wr_reg, busy_reg, done_reg, timeout_reg;
  logic [DATA_W-1:0] rd_data;

`ifdef MDR_SUBWORD_EN
  logic [1:0] size_reg;
  logic       sign_reg;

  // Capture access size and signedness when a read is accepted.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      size_reg <= 2'b00;
      sign_reg <= 1'b0;
    end else if (state_reg == IDLE && rd_req) begin
      size_reg <= size;
      sign_reg <= sign;
    end
  end

  // Select and extend the read field according to the latched access size.
  always_comb begin
    rd_data = MDataIn;
    case (size_reg)
      2'b00:   rd_data = {{(DATA_W-8){sign_reg & MDataIn[7]}}, MDataIn[7:0]};
      2'b01:   rd_data = {{(DATA_W-16){sign_reg & MDataIn[15]}}, MDataIn[15:0]};
      default: rd_data = MDataIn;
    endcase
  end
`else
  // Full-word reads only; size and sign have no effect in this build.
  logic unused_subword;
  assign unused_subword = ^{size, sign};
  assign rd_data = MDataIn;
`endif

  // Next-state, wait counter, MDR value and completion pulses.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    q_next       = q_reg;
    done_next    = 1'b0;
    timeout_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rd_req) begin
          state_next = RD_WAIT;
          cnt_next   = 8'd0;
        end else if (wr_req) begin
          state_next = WR_WAIT;
          cnt_next   = 8'd0;
        end else if (MDR_enable) begin
          q_next = BusMuxOut;
        end
      end
      RD_WAIT: begin
        if (mem_ack) begin
          q_next     = rd_data;
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg == LIMIT) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      WR_WAIT: begin
        if (mem_ack) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg == LIMIT) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus registered strobes decoded from the next state.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg   <= IDLE;
      cnt_reg     <= 8'd0;
      q_reg       <= '0;
      mem_rd_reg  <= 1'b0;
      mem_wr_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      q_reg       <= q_next;
      mem_rd_reg  <= (state_next == RD_WAIT);
      mem_wr_reg  <= (state_next == WR_WAIT);
      busy_reg    <= (state_next != IDLE);
      done_reg    <= done_next;
      timeout_reg <= timeout_next;
    end
  end

  assign Q         = q_reg;
  assign mem_wdata = q_reg;
  assign mem_rd    = mem_rd_reg;
  assign mem_wr    = mem_wr_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_mdr_mem_if.sv
// tb_mdr_mem_if: scoreboard bench for mdr_mem_if. Stimulus pushes the expected
// completion (kind, Q, strobe length); a monitor pops on every done/timeout.
module tb_mdr_mem_if;

  localparam int DW = 32;
  localparam int TO = 15;
`ifdef MDR_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic [DW-1:0] BusMuxOut = '0;
  logic          MDR_enable = 1'b0;
  logic          rd_req = 1'b0;
  logic          wr_req = 1'b0;
  logic [1:0]    size = 2'b10;
  logic          sign = 1'b0;
  logic [DW-1:0] MDataIn = '0;
  logic          mem_ack = 1'b0;
  logic          mem_rd, mem_wr, busy, done, timeout;
  logic [DW-1:0] mem_wdata, Q;

  typedef struct {
    bit          is_to;
    logic [31:0] q;
    int          len;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   strobe_cnt = 0;
  int   txn = 0;

  mdr_mem_if #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .clr(clr), .BusMuxOut(BusMuxOut), .MDR_enable(MDR_enable),
    .rd_req(rd_req), .wr_req(wr_req), .size(size), .sign(sign),
    .MDataIn(MDataIn), .mem_ack(mem_ack), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .Q(Q), .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push(input bit is_to, input logic [31:0] q, input int len);
    exp_t e;
    e.is_to = is_to;
    e.q     = q;
    e.len   = len;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every completion against the oldest expectation.
  always @(negedge clk) begin
    if (!clr) begin
      strobe_cnt = 0;
    end else begin
      chk("mem_wdata_eq_q", mem_wdata, Q);
      if (done && timeout) chk("done_and_timeout", 32'd1, 32'd0);
      if (done || timeout) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", {31'd0, done}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          txn++;
          $display("txn %0d: %s Q=%h strobe=%0d", txn, timeout ? "timeout" : "done", Q, strobe_cnt);
          chk("completion_kind", {31'd0, timeout}, {31'd0, e.is_to});
          chk("completion_q", Q, e.q);
          chk("strobe_len", strobe_cnt, e.len);
        end
        strobe_cnt = 0;
      end
      if (mem_rd || mem_wr) strobe_cnt++;
    end
  end

  // Read with a given ack delay (cycles of mem_rd); size/sign are scrambled
  // after acceptance so only the latched values may matter.
  task automatic do_read(input logic [1:0] sz, input logic sg, input logic [31:0] data, input int dly);
    @(negedge clk);
    rd_req = 1'b1; size = sz; sign = sg;
    @(negedge clk);
    rd_req = 1'b0; size = ~sz; sign = ~sg;
    repeat (dly - 1) @(negedge clk);
    mem_ack = 1'b1; MDataIn = data;
    @(negedge clk);
    mem_ack = 1'b0; MDataIn = 32'h0BAD_0BAD;
    @(negedge clk);
  endtask

  // Write with a given ack delay; dly == 0 means the memory never answers.
  task automatic do_write(input int dly);
    @(negedge clk);
    wr_req = 1'b1;
    @(negedge clk);
    wr_req = 1'b0;
    if (dly > 0) begin
      repeat (dly - 1) @(negedge clk);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
    end else begin
      repeat (TO + 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_q", Q, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    @(negedge clk);
    clr = 1'b1;

    // MDR load from bus
    @(negedge clk);
    MDR_enable = 1'b1; BusMuxOut = 32'h12345678;
    @(posedge clk); #1;
    MDR_enable = 1'b0;
    chk("load_q", Q, 32'h12345678);
    chk("load_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("load_mem_wr", {31'd0, mem_wr}, 32'd0);

    // mem_ack while idle must do nothing
    @(negedge clk);
    mem_ack = 1'b1; MDataIn = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_ack_q", Q, 32'h12345678);
    chk("idle_ack_busy", {31'd0, busy}, 32'd0);

    // Reads of each size and signedness
    push(1'b0, SUB ? 32'hFFFFFFF1 : 32'h876543F1, 3);
    do_read(2'b00, 1'b1, 32'h876543F1, 3);
    push(1'b0, SUB ? 32'h0000C321 : 32'h8765C321, 2);
    do_read(2'b01, 1'b0, 32'h8765C321, 2);
    push(1'b0, SUB ? 32'h000000F1 : 32'h876543F1, 1);
    do_read(2'b00, 1'b0, 32'h876543F1, 1);
    push(1'b0, SUB ? 32'hFFFFC321 : 32'h8765C321, 5);
    do_read(2'b01, 1'b1, 32'h8765C321, 5);
    push(1'b0, 32'hA5A55A5A, 2);
    do_read(2'b11, 1'b1, 32'hA5A55A5A, 2);

    // Write with no ack times out after exactly TO cycles of mem_wr
    @(negedge clk);
    MDR_enable = 1'b1; BusMuxOut = 32'hCAFEF00D;
    @(negedge clk);
    MDR_enable = 1'b0;
    push(1'b1, 32'hCAFEF00D, TO);
    do_write(0);
    chk("wr_to_wdata", mem_wdata, 32'hCAFEF00D);

    // Write acked normally, and ack exactly on the timeout limit edge
    push(1'b0, 32'hCAFEF00D, 2);
    do_write(2);
    push(1'b0, 32'hCAFEF00D, TO);
    do_write(TO);

    // Read timing out keeps Q
    push(1'b1, 32'hCAFEF00D, TO);
    @(negedge clk);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    repeat (TO + 2) @(negedge clk);

    // All requests at once, then requests while busy: read only
    push(1'b0, 32'h11223344, 4);
    @(negedge clk);
    rd_req = 1'b1; wr_req = 1'b1; MDR_enable = 1'b1; BusMuxOut = 32'hDEADBEEF; size = 2'b10;
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b1; MDR_enable = 1'b1; BusMuxOut = 32'h55555555;
    @(negedge clk);
    wr_req = 1'b0; MDR_enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mem_ack = 1'b1; MDataIn = 32'h11223344;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_queued_wr", {31'd0, mem_wr}, 32'd0);
      chk("no_queued_busy", {31'd0, busy}, 32'd0);
    end

    // Asynchronous reset mid-read; no completion afterwards
    @(negedge clk);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    #2 clr = 1'b0;
    #1;
    chk("midrst_q", Q, 32'h0);
    chk("midrst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    repeat (5) @(negedge clk);
    chk("postrst_busy", {31'd0, busy}, 32'd0);
    chk("postrst_q", Q, 32'h0);

    // Drain: every expected completion must have been seen
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
